// File: rtl/dmem_io_responder_pkg.sv
// Shared constants for the PMIPS data-side responder:
// IO page addresses, seven-segment glyphs and event bit positions.
package dmem_io_responder_pkg;

  localparam logic [15:0] ADDR_DISP   = 16'hFFF0;
  localparam logic [15:0] ADDR_SWSTAT = 16'hFFF2;
  localparam logic [15:0] ADDR_SWEVT  = 16'hFFF4;
  localparam logic [15:0] ADDR_TIMER  = 16'hFFF6;

  localparam int EV_SW0 = 0;
  localparam int EV_SW1 = 1;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG7_TBL = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_DISP,
    SEL_SWSTAT,
    SEL_SWEVT,
    SEL_TIMER
  } sel_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    return SEG7_TBL[d];
  endfunction

endpackage

// File: rtl/dmem_io_responder_debouncer.sv
// Two-flop synchronizer plus stability counter for one slide switch.
// o_rise pulses on the clock where the debounced value goes high.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          w_hit;

  assign w_hit = (r_s2 != r_db) &&
                 (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = w_hit & r_s2;

endmodule

// File: rtl/dmem_io_responder.sv
// Data-memory responder: word RAM at the bottom, IO page at the top
// (display, switch status, sticky switch events, prescaled timer).
import dmem_io_responder_pkg::*;

module dmem_io_responder #(
  parameter int RAM_AW          = 7,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMER_DIV       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        write,
  input  logic        read,
  output logic [15:0] rdata,
  input  logic        sw0,
  input  logic        sw1,
  output logic [6:0]  display
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [15:0]     r_ram [2**RAM_AW];
  logic [3:0]      r_disp;
  logic [6:0]      r_display;
  logic [1:0]      r_ev;
  logic [15:0]     r_timer;
  logic [PW-1:0]   r_presc;

  sel_e            w_sel;
  logic [RAM_AW-1:0] w_idx;
  logic [1:0]      w_db;
  logic [1:0]      w_rise;
  logic            w_evt_clr;
  logic            w_unused;

  assign w_idx    = addr[RAM_AW:1];
  assign w_unused = addr[0];

  always_comb begin
    w_sel = SEL_NONE;
    if (addr[15:RAM_AW+1] == '0)
      w_sel = SEL_RAM;
    else if (addr[15:1] == ADDR_DISP[15:1])
      w_sel = SEL_DISP;
    else if (addr[15:1] == ADDR_SWSTAT[15:1])
      w_sel = SEL_SWSTAT;
    else if (addr[15:1] == ADDR_SWEVT[15:1])
      w_sel = SEL_SWEVT;
    else if (addr[15:1] == ADDR_TIMER[15:1])
      w_sel = SEL_TIMER;
  end

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db0 (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (sw0),
    .o_db   (w_db[EV_SW0]),
    .o_rise (w_rise[EV_SW0])
  );

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db1 (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (sw1),
    .o_db   (w_db[EV_SW1]),
    .o_rise (w_rise[EV_SW1])
  );

  assign w_evt_clr = read && (w_sel == SEL_SWEVT);

  always_ff @(posedge clock) begin
    if (write && (w_sel == SEL_RAM))
      r_ram[w_idx] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_disp    <= 4'h0;
      r_display <= 7'b1000000;
      r_ev      <= 2'b00;
      r_timer   <= 16'h0000;
      r_presc   <= '0;
    end else begin
      if (write && (w_sel == SEL_DISP))
        r_disp <= wdata[3:0];
      r_display <= seg7(r_disp);
      // A set arriving with a read-clear wins.
      r_ev <= (w_evt_clr ? 2'b00 : r_ev) | w_rise;
      if (write && (w_sel == SEL_TIMER)) begin
        r_timer <= wdata;
        r_presc <= '0;
      end else if (r_presc == PW'(TIMER_DIV - 1)) begin
        r_timer <= r_timer + 16'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (read) begin
      unique case (w_sel)
        SEL_RAM:    rdata = r_ram[w_idx];
        SEL_DISP:   rdata = {12'h000, r_disp};
        SEL_SWSTAT: rdata = {14'h0000, w_db};
        SEL_SWEVT:  rdata = {14'h0000, r_ev};
        SEL_TIMER:  rdata = r_timer;
        default:    rdata = 16'h0000;
      endcase
    end
  end

  assign display = r_display;

endmodule

// File: doc/dmem_io_responder.md
Name: dmem_io_responder

Overview:
- Data-side responder for the PMIPS pipeline. It sits on the processor's data-memory bus (addr, wdata, write, read → rdata).
- Word RAM occupies low addresses. A memory-mapped IO page at the top of the address space holds:
  - 7-segment display register
  - debounced switch status
  - sticky switch-event flags
  - prescaled free-running timer
- Replaces the flat data-memory model on the board build. Load/store programs can poll switches and drive the display.

Parameters:
- RAM_AW, 7, RAM word-address width (128 words; byte addresses 0x0000–0x00FE).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a switch's debounced value changes.
- TIMER_DIV, 4, clocks per timer increment (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- addr  in  16  byte address from processor; bit 0 ignored (word access).
- wdata  in  16  store data.
- write  in  1  store enable, sampled at rising edge.
- read  in  1  load enable.
- rdata  out  16  load data, combinational from addr/read.
- sw0  in  1  raw slide switch 0, asynchronous, bouncy.
- sw1  in  1  raw slide switch 1, asynchronous, bouncy.
- display  out  7  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Address map (word-aligned):
  - RAM: addr[15:RAM_AW+1]==0.
  - DISP: 0xFFF0, R/W, bits[3:0].
  - SWSTAT: 0xFFF2, RO, {14'b0, sw1_db, sw0_db}.
  - SWEVT: 0xFFF4, read-clear, {14'b0, ev1, ev0}.
  - TIMER: 0xFFF6, R/W, 16-bit.
  - Any other address reads 0x0000; writes there are ignored.
- Reads:
  - rdata is zero-latency combinational, valid the same cycle read=1.
  - rdata=0x0000 when read=0.
- Writes commit at the rising edge where write=1.
- If read and write are both 1 to the same address: rdata shows the pre-write value; the new value is visible the next cycle.
- Reset (reset=0, async), outputs and state:
  - DISP=0, so display=7'b1000000.
  - Debounced switches=0, synchronizers=0, debounce counters=0.
  - Events=0, timer=0, prescaler=0.
  - RAM contents are not reset.
  - rdata follows the combinational rules above using these reset values.
- Display decode: hex 0–F of DISP[3:0], active-low. Values:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - display is registered-decoded: it updates on the clock after the DISP write.
- Debounce, per switch:
  - Raw input passes a 2-flop synchronizer.
  - A counter increments while the synchronized value differs from the debounced value; it clears on any match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced value takes the synchronized value and the counter clears.
  - Minimum latency from a raw edge to the debounced change is 2+DEBOUNCE_CYCLES clocks.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized samples never changes the debounced value.
- Events:
  - evN sets on the cycle swN_db rises 0→1.
  - A read of SWEVT clears all event bits at that edge.
  - If a read-clear and a set occur in the same cycle: the new set survives, and the read returns the old value.
  - A write to SWEVT is ignored.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1.
  - On prescaler wrap, the timer increments; 0xFFFF wraps to 0x0000.
  - A write to TIMER loads wdata and clears the prescaler; a write has priority over an increment in the same cycle.
- Reset mid-operation: all of the above state returns to reset values immediately, regardless of clock.

Decomposition:
- Shared package holds:
  - IO address constants: DISP/SWSTAT/SWEVT/TIMER.
  - The 16-entry seven-segment table.
  - The SWEVT bit positions.
- One sub-module: switch_debouncer (synchronizer + counter + rising-edge pulse output), instantiated for sw0 and sw1.
- RAM, register decode, timer and read mux are in the top.

Test Plan:
- Reset: pulse reset low mid-cycle → immediately display=1000000; reads of DISP, SWSTAT, SWEVT and TIMER all return 0x0000.
- RAM store/load:
  - Write 0x1234 @0x0004, then read @0x0004 → 0x1234.
  - Read @0x0006 after writing 0xBEEF there with bit 0 set (addr 0x0007) → 0xBEEF.
  - Read @0x0100 → 0x0000.
- Display: write 0x000A @0xFFF0 → next clock display=0001000; read @0xFFF0 → 0x000A.
- Debounce/events (DEBOUNCE_CYCLES=4):
  - sw0 high for 2 clocks then low → SWSTAT stays 0 and SWEVT stays 0.
  - sw0 held high → SWSTAT=0x0001 within 6 clocks, SWEVT=0x0001.
  - Read SWEVT → returns 0x0001, then 0x0000.
- Simultaneous: sw1_db rising edge in the same cycle as an SWEVT read → that read returns the old value; the next read returns 0x0002.
- Timer (TIMER_DIV=4):
  - Write 0xFFFE @0xFFF6 → reads 0xFFFF after 4 clocks, 0x0000 after 8 clocks.
  - Write 0x0000 on the same cycle as a scheduled increment → the timer reads 0x0000.
